// File: rtl/inst_queue.sv
// Instruction queue between the fetch byte-assembler and decode: a DEPTH-entry
// circular buffer of {inst, pc} pairs with a combinational head and a sticky drop flag.
module inst_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              inst_i,
  input  logic [31:0]              inst_pc_i,
  input  logic                     inst_enable_i,
  input  logic                     flush_i,
  input  logic                     stall_i,
  output logic [31:0]              inst_o,
  output logic [31:0]              pc_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          overflow;

  logic          is_empty;
  logic          is_full;
  logic          pop;
  logic          push;
  logic          drop;

  // Handshake: decode takes the head when valid_o is high and stall_i is low
  // (stall_i acts as !ready). Fetch offers one pulse on inst_enable_i per
  // instruction; a full queue still accepts it if the head leaves that cycle,
  // otherwise the pulse is lost and overflow_o latches. flush_i beats both.
  always_comb begin
    is_empty = (count == '0);
    is_full  = (count == FULL_COUNT);
    pop      = !is_empty && !stall_i && !flush_i;
    push     = inst_enable_i && !flush_i && (!is_full || pop);
    drop     = inst_enable_i && !flush_i && is_full && !pop;
  end

  // Storage is deliberately left without reset; count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= inst_i;
      pc_mem[wr_ptr]   <= inst_pc_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    valid_o    = !is_empty;
    full_o     = is_full;
    count_o    = count;
    overflow_o = overflow;
    inst_o     = is_empty ? 32'h0 : inst_mem[rd_ptr];
    pc_o       = is_empty ? 32'h0 : pc_mem[rd_ptr];
  end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_inst_queue;

  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst;
  logic [31:0]   inst_i;
  logic [31:0]   inst_pc_i;
  logic          inst_enable_i;
  logic          flush_i;
  logic          stall_i;
  logic [31:0]   inst_o;
  logic [31:0]   pc_o;
  logic          valid_o;
  logic          full_o;
  logic [CW-1:0] count_o;
  logic          overflow_o;

  int n_compared;
  int n_mismatched;

  // Reference model: queue of {inst, pc} in push order, plus sticky overflow.
  logic [63:0] exp_q[$];
  logic        exp_ovf;

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .inst_i        (inst_i),
    .inst_pc_i     (inst_pc_i),
    .inst_enable_i (inst_enable_i),
    .flush_i       (flush_i),
    .stall_i       (stall_i),
    .inst_o        (inst_o),
    .pc_o          (pc_o),
    .valid_o       (valid_o),
    .full_o        (full_o),
    .count_o       (count_o),
    .overflow_o    (overflow_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: apply one cycle of inputs, advance the model across the edge,
  // return 1 time unit after the edge with the pulse inputs cleared.
  task automatic step(input logic en, input logic [31:0] inst, input logic [31:0] pc,
                      input logic stall, input logic flush);
    logic m_pop;
    logic m_push;
    logic m_drop;
    inst_enable_i = en;
    inst_i        = inst;
    inst_pc_i     = pc;
    stall_i       = stall;
    flush_i       = flush;
    m_pop  = (exp_q.size() != 0) && !stall && !flush;
    m_push = en && !flush && ((exp_q.size() < DEPTH) || m_pop);
    m_drop = en && !flush && (exp_q.size() == DEPTH) && !m_pop;
    @(posedge clk);
    if (flush) begin
      exp_q.delete();
    end else begin
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) exp_q.push_back({inst, pc});
      if (m_drop) exp_ovf = 1'b1;
    end
    #1;
    inst_enable_i = 1'b0;
    flush_i       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    inst_enable_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
    inst_i = '0; inst_pc_i = '0;
    exp_q.delete();
    exp_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_compared++;
    if ({valid_o, full_o, count_o, overflow_o} !== {1'b0, 1'b0, CW'(0), 1'b0}) begin
      n_mismatched++;
      $display("FAIL reset_flags: got v=%0b f=%0b c=%0d o=%0b want 0 0 0 0",
               valid_o, full_o, count_o, overflow_o);
    end
    n_compared++;
    if ({inst_o, pc_o} !== 64'h0) begin
      n_mismatched++;
      $display("FAIL reset_head: got inst=%h pc=%h want 0 0", inst_o, pc_o);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill_drain();
    logic [31:0] want_pc;
    for (int i = 0; i < DEPTH; i++) step(1'b1, $urandom, 32'(i * 4), 1'b1, 1'b0);
    n_compared++;
    if ({full_o, count_o, pc_o} !== {1'b1, CW'(DEPTH), 32'h0}) begin
      n_mismatched++;
      $display("FAIL fill_full: got f=%0b c=%0d pc=%h want 1 %0d 0", full_o, count_o, pc_o, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      want_pc = 32'(i * 4);
      n_compared++;
      if (pc_o !== want_pc || inst_o !== exp_q[0][63:32] || valid_o !== 1'b1) begin
        n_mismatched++;
        $display("FAIL drain_order[%0d]: got v=%0b pc=%h inst=%h want 1 %h %h",
                 i, valid_o, pc_o, inst_o, want_pc, exp_q[0][63:32]);
      end
      step(1'b0, '0, '0, 1'b0, 1'b0);
    end
    n_compared++;
    if ({valid_o, count_o, inst_o, pc_o} !== {1'b0, CW'(0), 64'h0}) begin
      n_mismatched++;
      $display("FAIL drain_empty: got v=%0b c=%0d inst=%h pc=%h want 0 0 0 0",
               valid_o, count_o, inst_o, pc_o);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) step(1'b1, $urandom, 32'(i * 4), 1'b1, 1'b0);
    n_compared++;
    if (overflow_o !== 1'b0) begin
      n_mismatched++;
      $display("FAIL ovf_before: got %0b want 0", overflow_o);
    end
    step(1'b1, 32'hDEADBEEF, 32'h100, 1'b1, 1'b0);
    n_compared++;
    if ({overflow_o, count_o, full_o, pc_o} !== {1'b1, CW'(DEPTH), 1'b1, 32'h0}) begin
      n_mismatched++;
      $display("FAIL ovf_drop: got o=%0b c=%0d f=%0b pc=%h want 1 %0d 1 0",
               overflow_o, count_o, full_o, pc_o, DEPTH);
    end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] want_pc;
    step(1'b1, 32'h1234_0010, 32'h10, 1'b0, 1'b0);
    n_compared++;
    if ({count_o, full_o, pc_o} !== {CW'(DEPTH), 1'b1, 32'h4}) begin
      n_mismatched++;
      $display("FAIL full_push_pop: got c=%0d f=%0b pc=%h want %0d 1 4", count_o, full_o, pc_o, DEPTH);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      want_pc = (i == DEPTH) ? 32'h10 : 32'(i * 4);
      n_compared++;
      if (valid_o !== 1'b1 || pc_o !== want_pc || inst_o !== exp_q[0][63:32]) begin
        n_mismatched++;
        $display("FAIL full_push_pop_order[%0d]: got v=%0b pc=%h inst=%h want 1 %h %h",
                 i, valid_o, pc_o, inst_o, want_pc, exp_q[0][63:32]);
      end
      step(1'b0, '0, '0, 1'b0, 1'b0);
    end
    n_compared++;
    if (valid_o !== 1'b0 || overflow_o !== 1'b1) begin
      n_mismatched++;
      $display("FAIL full_push_pop_end: got v=%0b o=%0b want 0 1", valid_o, overflow_o);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) step(1'b1, $urandom, 32'h20 + 32'(i * 4), 1'b1, 1'b0);
    step(1'b1, 32'hAAAA_5555, 32'h30, 1'b0, 1'b1);
    n_compared++;
    if ({count_o, valid_o, inst_o, pc_o} !== {CW'(0), 1'b0, 64'h0}) begin
      n_mismatched++;
      $display("FAIL flush_clear: got c=%0d v=%0b inst=%h pc=%h want 0 0 0 0",
               count_o, valid_o, inst_o, pc_o);
    end
    n_compared++;
    if (overflow_o !== 1'b1) begin
      n_mismatched++;
      $display("FAIL flush_keeps_ovf: got %0b want 1", overflow_o);
    end
    step(1'b1, 32'h0BAD_F00D, 32'h40, 1'b1, 1'b0);
    n_compared++;
    if ({valid_o, count_o, pc_o, inst_o} !== {1'b1, CW'(1), 32'h40, 32'h0BAD_F00D}) begin
      n_mismatched++;
      $display("FAIL flush_then_push: got v=%0b c=%0d pc=%h inst=%h want 1 1 40 0badf00d",
               valid_o, count_o, pc_o, inst_o);
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, $urandom, 32'h44, 1'b1, 1'b0);
    n_compared++;
    if (count_o !== CW'(2)) begin
      n_mismatched++;
      $display("FAIL areset_setup: got c=%0d want 2", count_o);
    end
    #2;
    rst = 1'b0;
    #1;
    exp_q.delete();
    exp_ovf = 1'b0;
    n_compared++;
    if ({count_o, valid_o, overflow_o, full_o, inst_o, pc_o} !== {CW'(0), 3'b000, 64'h0}) begin
      n_mismatched++;
      $display("FAIL areset_immediate: got c=%0d v=%0b o=%0b f=%0b inst=%h pc=%h want all 0",
               count_o, valid_o, overflow_o, full_o, inst_o, pc_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    stall_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random(input int cycles, input int flush_pct);
    logic [31:0] next_pc;
    logic [31:0] want_inst;
    logic [31:0] want_pc;
    int          popped;
    popped  = 0;
    next_pc = 32'h1000;
    for (int c = 0; c < cycles; c++) begin
      logic en;
      logic st;
      logic fl;
      en = ($urandom_range(0, 99) < 70);
      st = ($urandom_range(0, 99) < 35);
      fl = ($urandom_range(0, 99) < flush_pct);
      if (exp_q.size() != 0 && !st && !fl) popped++;
      step(en, $urandom, next_pc, st, fl);
      if (en) next_pc = next_pc + 32'h4;
      want_inst = (exp_q.size() != 0) ? exp_q[0][63:32] : 32'h0;
      want_pc   = (exp_q.size() != 0) ? exp_q[0][31:0]  : 32'h0;
      n_compared++;
      if ({valid_o, full_o, count_o, overflow_o, inst_o, pc_o} !==
          {exp_q.size() != 0, exp_q.size() == DEPTH, CW'(exp_q.size()), exp_ovf, want_inst, want_pc}) begin
        n_mismatched++;
        $display("FAIL random[%0d]: got v=%0b f=%0b c=%0d o=%0b inst=%h pc=%h want v=%0b f=%0b c=%0d o=%0b inst=%h pc=%h",
                 c, valid_o, full_o, count_o, overflow_o, inst_o, pc_o,
                 exp_q.size() != 0, exp_q.size() == DEPTH, exp_q.size(), exp_ovf, want_inst, want_pc);
      end
    end
    n_compared++;
    if (popped < 10) begin
      n_mismatched++;
      $display("FAIL random_traffic: got %0d pops want at least 10", popped);
    end
    stall_i = 1'b0;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_full_push_pop();
    test_flush();
    test_async_reset();
    test_random(200, 0);
    test_random(300, 4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
